// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: default widths, demux select codes and
// the data-memory sequencer state type.
package cpu_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 4;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_IMM = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } mem_state_e;

endpackage

// File: rtl/ram_sp.sv
// Single-port word RAM: synchronous write, combinational read, no reset.
module ram_sp #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/data_mem_unit.sv
// Data-memory stage: single-cycle writes, fixed-latency reads sequenced by an
// IDLE/WAIT/RESP FSM, response held until the consumer takes it.
module data_mem_unit
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] data_input_mem,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  busy
);

    localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        CNT_W'((READ_LATENCY >= 2) ? (READ_LATENCY - 2) : 0);

    if ((READ_LATENCY < 1) || (READ_LATENCY > 8)) begin : g_bad_latency
        $error("data_mem_unit: READ_LATENCY must be in 1..8");
    end

    mem_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  busy_q, busy_d;

    logic                  req_fire;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign req_fire = req_valid && (state_q == IDLE);
    assign ram_we   = req_fire && req_write;
    // The single port follows the request in IDLE (writes, and the 1-cycle
    // read) and the latched read address otherwise.
    assign ram_addr = (state_q == IDLE) ? req_addr : addr_q;

    ram_sp #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(data_input_mem),
        .rdata(ram_rdata)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (req_fire && !req_write) begin
                    addr_d = req_addr;
                    if (READ_LATENCY == 1) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = ram_rdata;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = ram_rdata;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: three instances (latency 2, 1, 4) checked against
// an array memory model with latency/handshake expectations.
module tb_data_mem_unit;

    localparam int LAT [3] = '{2, 1, 4};

    logic            clk;
    logic            rst_n;
    logic [2:0]      req_valid;
    logic [2:0]      req_ready;
    logic [2:0]      req_write;
    logic [2:0][3:0] req_addr;
    logic [2:0][7:0] wdata;
    logic [2:0]      rsp_valid;
    logic [2:0]      rsp_ready;
    logic [2:0][7:0] rsp_data;
    logic [2:0]      busy;

    logic [7:0] mdl_mem [3][16];
    bit         mdl_wr  [3][16];

    int n_cmp  = 0;
    int n_fail = 0;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        data_mem_unit #(
            .DATA_WIDTH  (8),
            .ADDR_WIDTH  (4),
            .READ_LATENCY(LAT[gi])
        ) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .req_valid     (req_valid[gi]),
            .req_ready     (req_ready[gi]),
            .req_write     (req_write[gi]),
            .req_addr      (req_addr[gi]),
            .data_input_mem(wdata[gi]),
            .rsp_valid     (rsp_valid[gi]),
            .rsp_ready     (rsp_ready[gi]),
            .rsp_data      (rsp_data[gi]),
            .busy          (busy[gi])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_write(input int d, input logic [3:0] a, input logic [7:0] v);
        @(negedge clk);
        n_cmp++;
        if (req_ready[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_ready dut%0d addr=%0d: got %b want 1", d, a, req_ready[d]);
        end
        req_valid[d] = 1'b1;
        req_write[d] = 1'b1;
        req_addr[d]  = a;
        wdata[d]     = v;
        @(posedge clk);
        mdl_mem[d][a] = v;
        mdl_wr[d][a]  = 1'b1;
        $display("dut%0d WR addr=%0d data=%02h", d, a, v);
    endtask

    task automatic idle(input int d);
        @(negedge clk);
        req_valid[d] = 1'b0;
    endtask

    // Read with 'stall' cycles of rsp_ready low; optionally pokes a write
    // to the same address while the unit is not ready (must be ignored).
    task automatic do_read(input int d, input logic [3:0] a, input int stall, input bit poke);
        int         cyc;
        logic [7:0] exp;
        bit         known;
        exp   = mdl_mem[d][a];
        known = mdl_wr[d][a];
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_write[d] = 1'b0;
        req_addr[d]  = a;
        rsp_ready[d] = (stall == 0);
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
        cyc = 1;
        while (rsp_valid[d] !== 1'b1 && cyc < 20) begin
            n_cmp++;
            if (busy[d] !== 1'b1 || req_ready[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL wait_busy dut%0d cyc=%0d: busy=%b req_ready=%b want 1/0", d, cyc, busy[d], req_ready[d]);
            end
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (cyc != LAT[d]) begin
            n_fail++;
            $display("FAIL latency dut%0d addr=%0d: got %0d want %0d", d, a, cyc, LAT[d]);
        end
        n_cmp++;
        if (busy[d] !== 1'b1 || req_ready[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL resp_busy dut%0d: busy=%b req_ready=%b want 1/0", d, busy[d], req_ready[d]);
        end
        if (known) begin
            n_cmp++;
            if (rsp_data[d] !== exp) begin
                n_fail++;
                $display("FAIL rd_data dut%0d addr=%0d: got %02h want %02h", d, a, rsp_data[d], exp);
            end
        end
        for (int i = 1; i <= stall; i++) begin
            if (poke) begin
                req_valid[d] = 1'b1;
                req_write[d] = 1'b1;
                req_addr[d]  = a;
                wdata[d]     = 8'h11;
            end
            @(negedge clk);
            n_cmp++;
            if (rsp_valid[d] !== 1'b1 || (known && rsp_data[d] !== exp) || req_ready[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL hold dut%0d cyc=%0d: valid=%b data=%02h ready=%b want 1/%02h/0",
                         d, i, rsp_valid[d], rsp_data[d], req_ready[d], exp);
            end
        end
        req_valid[d] = 1'b0;
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (rsp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1 || busy[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL after_xfer dut%0d: valid=%b ready=%b busy=%b want 0/1/0",
                     d, rsp_valid[d], req_ready[d], busy[d]);
        end
        if (known) begin
            n_cmp++;
            if (rsp_data[d] !== exp) begin
                n_fail++;
                $display("FAIL retain dut%0d: got %02h want %02h", d, rsp_data[d], exp);
            end
        end
        $display("dut%0d RD addr=%0d data=%02h lat=%0d stall=%0d", d, a, rsp_data[d], cyc, stall);
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        wdata     = '0;
        rsp_ready = '1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (rsp_valid[d] !== 1'b0 || busy[d] !== 1'b0 || rsp_data[d] !== 8'h00 || req_ready[d] !== 1'b1) begin
                n_fail++;
                $display("FAIL reset dut%0d: valid=%b busy=%b data=%02h ready=%b want 0/0/00/1",
                         d, rsp_valid[d], busy[d], rsp_data[d], req_ready[d]);
            end
        end
        rst_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_single;
        do_write(0, 4'd3, 8'hA5);
        do_read(0, 4'd3, 0, 1'b0);
    endtask

    task automatic test_backpressure;
        do_read(0, 4'd3, 5, 1'b1);
        do_read(0, 4'd3, 0, 1'b0);
    endtask

    task automatic test_streaming;
        for (int a = 0; a < 16; a++) do_write(0, 4'(a), 8'(a));
        idle(0);
        do_read(0, 4'd15, 0, 1'b0);
        do_read(0, 4'd0, 0, 1'b0);
        do_read(0, 4'd7, 0, 1'b0);
    endtask

    task automatic test_latency_sweep;
        for (int d = 1; d < 3; d++) begin
            do_write(d, 4'd6, 8'(8'h5A + d));
            idle(d);
            do_read(d, 4'd6, 0, 1'b0);
            do_read(d, 4'd6, 2, 1'b0);
        end
    endtask

    task automatic test_aliasing;
        for (int d = 0; d < 3; d++) begin
            do_write(d, 4'd9, 8'h3C);
            do_read(d, 4'd9, 0, 1'b0);
        end
    endtask

    task automatic test_async_reset;
        for (int d = 0; d < 3; d++) do_write(d, 4'd3, 8'(8'h70 + d));
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            req_valid[d] = 1'b1;
            req_write[d] = 1'b0;
            req_addr[d]  = 4'd3;
            rsp_ready[d] = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        n_cmp++;
        if (busy !== 3'b111 || rsp_valid[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: busy=%b valid1=%b want 111/1", busy, rsp_valid[1]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (rsp_valid !== 3'b000 || busy !== 3'b000) begin
            n_fail++;
            $display("FAIL async_clear: valid=%b busy=%b want 000/000", rsp_valid, busy);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = '1;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 3'b111 || rsp_valid !== 3'b000) begin
            n_fail++;
            $display("FAIL post_reset: ready=%b valid=%b want 111/000", req_ready, rsp_valid);
        end
        $display("async reset mid-read done");
        for (int d = 0; d < 3; d++) do_read(d, 4'd3, 0, 1'b0);
    endtask

    task automatic test_random;
        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 30; n++) begin
                logic [3:0] a;
                a = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 1) == 1) begin
                    do_write(d, a, 8'($urandom));
                end else begin
                    do_read(d, a, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
                end
            end
            idle(d);
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++)
            for (int a = 0; a < 16; a++) mdl_wr[d][a] = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_streaming();
        test_latency_sweep();
        test_aliasing();
        test_async_reset();
        test_random();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
